// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose:
//   MIPS-style ALU execution unit with a valid/ready request side and a
//   valid/ready result side. Single-cycle ops finish one cycle after
//   acceptance. MULT/MULTU run an iterative shift-add multiplier over
//   WIDTH cycles.
//
// Configuration:
//   ALU_EXEC_MULT_EN : when defined, builds the MUL state and the iterative
//                      multiplier. When undefined, MULT/MULTU decode as
//                      illegal and complete with latency 1.
//
// Ports:
//   clk        : clock; all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request valid
//   in_ready   : unit can accept a request (high only in IDLE)
//   Operation  : 00 add, 01 sub, 10 R-type (decode by Function), 11 reserved
//   Function   : R-type function field
//   A, B       : operands (shifts operate on B, MIPS rt style)
//   Shamt      : shift amount
//   out_valid  : result valid (high only in DONE)
//   out_ready  : consumer accepts the result
//   Result     : result, or low half of the product
//   Hi         : high half of the product; 0 for non-multiply ops
//   Zero       : registered Result == 0
//   Illegal    : unsupported Operation/Function combination
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. The producer holds its payload while valid is high and ready
// is low; request-side inputs are only sampled on the accepting edge, and
// in_valid in any other state is ignored (nothing is queued).
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                Operation,
  input  logic [5:0]                Function,
  input  logic [WIDTH-1:0]          A,
  input  logic [WIDTH-1:0]          B,
  input  logic [$clog2(WIDTH)-1:0]  Shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          Result,
  output logic [WIDTH-1:0]          Hi,
  output logic                      Zero,
  output logic                      Illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_EXEC_MULT_EN
    S_MUL  = 2'd1,
`endif
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  // Single-cycle decode of the live request; only consumed on acceptance.
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;

`ifdef ALU_EXEC_MULT_EN
  logic               is_mul;
  logic               mul_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_final;
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef ALU_EXEC_MULT_EN
    is_mul     = 1'b0;
    mul_signed = 1'b0;
`endif
    case (Operation)
      2'b00: alu_res = A + B;
      2'b01: alu_res = A - B;
      2'b10: begin
        case (Function)
          FN_ADD:  alu_res = A + B;
          FN_SUB:  alu_res = A - B;
          FN_AND:  alu_res = A & B;
          FN_OR:   alu_res = A | B;
          FN_XOR:  alu_res = A ^ B;
          FN_NOR:  alu_res = ~(A | B);
          FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
          FN_SLL:  alu_res = B << Shamt;
          FN_SRL:  alu_res = B >> Shamt;
          FN_SRA:  alu_res = $unsigned($signed(B) >>> Shamt);
`ifdef ALU_EXEC_MULT_EN
          FN_MULT: begin
            is_mul     = 1'b1;
            mul_signed = 1'b1;
          end
          FN_MULTU: is_mul = 1'b1;
`else
          FN_MULT, FN_MULTU: alu_ill = 1'b1;
`endif
          default: alu_ill = 1'b1;
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MULT_EN
  // The multiplier works on magnitudes; sign is reapplied at the end.
  assign a_mag = (mul_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag = (mul_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // prod_q = {partial high, remaining multiplier bits}. Each step adds the
  // multiplicand into the high half when the current LSB is set, then
  // shifts the whole thing right, keeping the carry out of the add.
  assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign prod_step  = {mul_sum, prod_q[WIDTH-1:1]};
  assign prod_final = neg_q ? (~prod_step + 1'b1) : prod_step;
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MULT_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_EXEC_MULT_EN
          if (is_mul) begin
            state_d = S_MUL;
            mcand_d = a_mag;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            neg_d   = mul_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt_d   = '0;
          end else begin
`endif
            state_d   = S_DONE;
            result_d  = alu_res;
            hi_d      = '0;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
`ifdef ALU_EXEC_MULT_EN
          end
`endif
        end
      end
`ifdef ALU_EXEC_MULT_EN
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + SHW'(1);
        // The final iteration writes the signed-corrected product directly.
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d   = S_DONE;
          hi_d      = prod_final[2*WIDTH-1:WIDTH];
          result_d  = prod_final[WIDTH-1:0];
          zero_d    = (prod_final[WIDTH-1:0] == '0);
          illegal_d = 1'b0;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MULT_EN
      mcand_q   <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MULT_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign Hi        = hi_q;
  assign Zero      = zero_q;
  assign Illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal values: 8, 16, 32, 64).
REQ-002 SHALL derive localparam SHW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port Operation  input  2  main-decoder ALU op: 00 add, 01 sub, 10 R-type, 11 reserved.
REQ-008 SHALL have port Function  input  6  R-type function field.
REQ-009 SHALL have ports A and B  input  WIDTH each  operands.
REQ-010 SHALL have port Shamt  input  SHW  shift amount.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port Result  output  WIDTH  result, or low half of the product.
REQ-014 SHALL have port Hi  output  WIDTH  high half of the product; 0 for non-multiply ops.
REQ-015 SHALL have port Zero  output  1  asserted when Result == 0.
REQ-016 SHALL have port Illegal  output  1  Operation/Function combination is unsupported.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-018 Handshake: request is accepted when in_valid & in_ready; operands, Operation, Function and Shamt are latched on acceptance.
REQ-019 Decode for Operation 00 and 01 SHALL be ADD and SUB respectively; Function is ignored.
REQ-020 Decode for Operation 10 SHALL be by Function: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT (signed); 101011 SLTU; 000000 SLL; 000010 SRL; 000011 SRA; 011000 MULT (signed); 011001 MULTU.
REQ-021 Operation 11 and any unlisted Function SHALL give Illegal = 1, Result = 0, Hi = 0.
REQ-022 Add and sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-023 Single-cycle ops (all except MULT/MULTU) SHALL go IDLE -> DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-024 MULT/MULTU SHALL go IDLE -> MUL and run a WIDTH-iteration shift-add on operand magnitudes, then MUL -> DONE.
REQ-025 For MULT/MULTU, out_valid SHALL assert WIDTH+1 cycles after acceptance; {Hi, Result} = full 2*WIDTH-bit product; for MULT the product is negated when operand signs differ.
REQ-026 In DONE, out_valid = 1; Result, Hi, Zero and Illegal SHALL hold stable until out_ready = 1, then the FSM moves to IDLE.
REQ-027 in_valid in a non-IDLE state SHALL be ignored; no queuing.
REQ-028 Zero SHALL be registered together with Result, not computed from the live operands.

Reset
REQ-029 While rst_n = 0, the FSM SHALL be in IDLE with in_ready = 1 and out_valid, Result, Hi, Zero, Illegal = 0.
REQ-030 Reset during MUL or DONE SHALL abort the operation and discard its result; the next accepted request executes correctly.

Configuration
REQ-031 Macro ALU_EXEC_MULT_EN defined SHALL compile in the MUL state and the iterative multiplier per REQ-024 and REQ-025.
REQ-032 Macro ALU_EXEC_MULT_EN undefined SHALL remove the MUL state and the multiplier; MULT/MULTU then decode as illegal per REQ-021, with latency 1.

Verification (WIDTH = 32, ALU_EXEC_MULT_EN defined)
REQ-033 Assert rst_n = 0 mid-stream -> out_valid = 0, Result = 0, in_ready = 1; release -> accepts on the next in_valid.
REQ-034 Op 10, Function 100010, A = 5, B = 5 -> next cycle out_valid = 1, Result = 0, Zero = 1; repeat with Op 00, A = 0xFFFFFFFF, B = 1 -> Result = 0, Zero = 1 (wrap).
REQ-035 SLT with A = 0xFFFFFFFF, B = 1 -> Result = 1; SLTU with the same operands -> Result = 0; SRA of 0x80000000 with Shamt = 4 -> 0xF8000000.
REQ-036 MULT with A = 0xFFFFFFFD, B = 7 -> out_valid 33 cycles after accept, Hi = 0xFFFFFFFF, Result = 0xFFFFFFEB; MULTU with the same operands -> Hi = 0x00000006, Result = 0xFFFFFFEB.
REQ-037 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
REQ-038 Op 11, or Op 10 with Function 111111 -> Illegal = 1, Result = 0; rst_n low 10 cycles into a MULT -> abort, and the following ADD 2 + 3 -> Result = 5.
